sync_load_counter: RTL and testbench

- Parameterisable binary up-counter with synchronous parallel load, count enable and a wrap-around (overflow) indication.
- General-purpose timing/event counter for datapath and control logic, driven by the system clock.
- Outputs are fully registered.

---
 rtl/sync_load_counter_pkg.sv | 18 +
 rtl/sync_load_counter.sv | 60 ++++++
 tb/tb_sync_load_counter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_load_counter_pkg.sv
// Shared constants for the loadable up-counter: default width and a
// width-aware constant helper used for reset and comparison values.
package sync_load_counter_pkg;

  localparam int unsigned DEFAULT_COUNTER_SIZE = 32'd32;

  // Returns all-ones or zero for the low 'width' bits (width 1..64).
  function automatic logic [63:0] cnt_const(input int unsigned width, input logic ones);
    logic [63:0] value_s;
    if (ones) begin
      value_s = {64{1'b1}} >> (32'd64 - width);
    end else begin
      value_s = 64'd0;
    end
    return value_s;
  endfunction

endpackage

// File: rtl/sync_load_counter.sv
// Binary up-counter with synchronous parallel load, count enable and a
// registered one-cycle overflow pulse on wrap from all-ones to zero.
module sync_load_counter
  import sync_load_counter_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = DEFAULT_COUNTER_SIZE
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [COUNTER_SIZE-1:0] cnt_in,
  output logic [COUNTER_SIZE-1:0] cnt_out,
  output logic                    overflow
);

  localparam logic [COUNTER_SIZE-1:0] CNT_ZERO = COUNTER_SIZE'(cnt_const(COUNTER_SIZE, 1'b0));

  logic [COUNTER_SIZE-1:0] cnt_r;
  logic                    ovf_r;
  logic [COUNTER_SIZE-1:0] cnt_nxt_s;
  logic                    ovf_nxt_s;
  logic [COUNTER_SIZE:0]   inc_s;

  // Next count and overflow: load beats enable, carry out of the increment flags a wrap.
  always_comb begin
    inc_s     = {1'b0, cnt_r} + {{COUNTER_SIZE{1'b0}}, 1'b1};
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = 1'b0;
    case ({load, enable})
      2'b10, 2'b11: begin
        cnt_nxt_s = cnt_in;
        ovf_nxt_s = 1'b0;
      end
      2'b01: begin
        cnt_nxt_s = inc_s[COUNTER_SIZE-1:0];
        ovf_nxt_s = inc_s[COUNTER_SIZE];
      end
      default: begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = 1'b0;
      end
    endcase
  end

  // Count and overflow state registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_r <= CNT_ZERO;
      ovf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign cnt_out  = cnt_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_sync_load_counter.sv
// Self-checking bench for sync_load_counter: directed scenarios plus random
// load/enable traffic against an arithmetic reference model.
module tb_sync_load_counter;

  logic        clk = 1'b0;
  logic        res_n;
  logic        enable;
  logic        load;
  logic [31:0] cnt_in;
  logic [31:0] cnt_out;
  logic        overflow;

  logic        res4_n;
  logic        en4;
  logic        load4;
  logic [3:0]  cnt_in4;
  logic [3:0]  cnt_out4;
  logic        ovf4;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_cnt;
  logic        m_ovf;

  sync_load_counter #(.COUNTER_SIZE(32)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .load(load),
    .cnt_in(cnt_in), .cnt_out(cnt_out), .overflow(overflow)
  );

  sync_load_counter #(.COUNTER_SIZE(4)) dut4 (
    .clk(clk), .res_n(res4_n), .enable(en4), .load(load4),
    .cnt_in(cnt_in4), .cnt_out(cnt_out4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive inputs, take one rising edge, advance the model; leaves time at posedge+1.
  task automatic drive_step(input logic ld, input logic en, input logic [31:0] val);
    longint unsigned sum;
    load   = ld;
    enable = en;
    cnt_in = val;
    @(posedge clk);
    #1;
    if (ld) begin
      m_cnt = val;
      m_ovf = 1'b0;
    end else if (en) begin
      sum   = longint'(m_cnt) + 1;
      m_ovf = (sum == 64'h1_0000_0000);
      m_cnt = 32'(sum % 64'h1_0000_0000);
    end else begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0; enable = 1'b1; load = 1'b0; cnt_in = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (cnt_out !== 32'd0 || overflow !== 1'b0) begin
        $display("FAIL reset_hold: cnt_out=%h overflow=%b, want 0/0", cnt_out, overflow);
        bad++;
      end
    end
    res_n = 1'b1;
    m_cnt = 32'd0; m_ovf = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive_step(1'b0, 1'b1, 32'd0);
      total++;
      if (cnt_out !== 32'(i) || overflow !== 1'b0) begin
        $display("FAIL count_up: step %0d cnt_out=%0d overflow=%b, want %0d/0", i, cnt_out, overflow, i);
        bad++;
      end
    end
  endtask

  task automatic test_pause();
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_step(1'b0, 1'b0, 32'd0);
      total++;
      if (cnt_out !== 32'd10 || overflow !== 1'b0) begin
        $display("FAIL pause_hold: cycle %0d cnt_out=%0d overflow=%b, want 10/0", i, cnt_out, overflow);
        bad++;
      end
    end
    for (int i = 11; i <= 15; i++) begin
      drive_step(1'b0, 1'b1, 32'd0);
      total++;
      if (cnt_out !== 32'(i) || overflow !== 1'b0) begin
        $display("FAIL pause_resume: cnt_out=%0d overflow=%b, want %0d/0", cnt_out, overflow, i);
        bad++;
      end
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; enable = 1'b1; cnt_in = 32'h0000_1234;
    #2;
    total++;
    if (cnt_out !== 32'd15) begin
      $display("FAIL no_comb_path: cnt_out=%h before edge, want %h", cnt_out, 32'd15);
      bad++;
    end
    drive_step(1'b1, 1'b1, 32'h0000_1234);
    total++;
    if (cnt_out !== 32'h0000_1234 || overflow !== 1'b0) begin
      $display("FAIL load_priority: cnt_out=%h overflow=%b, want 00001234/0", cnt_out, overflow);
      bad++;
    end
    drive_step(1'b0, 1'b1, 32'h0);
    total++;
    if (cnt_out !== 32'h0000_1235) begin
      $display("FAIL load_then_count: cnt_out=%h, want 00001235", cnt_out);
      bad++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [3];
    logic        exp_ovf [3];
    exp_seq = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    exp_ovf = '{1'b0, 1'b1, 1'b0};
    drive_step(1'b1, 1'b0, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b0, 1'b1, 32'h0);
      total++;
      if (cnt_out !== exp_seq[i] || overflow !== exp_ovf[i]) begin
        $display("FAIL wrap: step %0d cnt_out=%h overflow=%b, want %h/%b", i, cnt_out, overflow, exp_seq[i], exp_ovf[i]);
        bad++;
      end
    end
    drive_step(1'b1, 1'b1, 32'hFFFF_FFFF);
    total++;
    if (cnt_out !== 32'hFFFF_FFFF || overflow !== 1'b0) begin
      $display("FAIL load_ones: cnt_out=%h overflow=%b, want ffffffff/0", cnt_out, overflow);
      bad++;
    end
    drive_step(1'b0, 1'b1, 32'h0);
    total++;
    if (cnt_out !== 32'h0 || overflow !== 1'b1) begin
      $display("FAIL wrap_after_load: cnt_out=%h overflow=%b, want 0/1", cnt_out, overflow);
      bad++;
    end
    drive_step(1'b0, 1'b0, 32'h0);
    total++;
    if (cnt_out !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL ovf_not_sticky: cnt_out=%h overflow=%b, want 0/0", cnt_out, overflow);
      bad++;
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic        en;
    logic [31:0] val;
    for (int i = 0; i < 300; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      val = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : 32'($urandom);
      drive_step(ld, en, val);
      total++;
      if (cnt_out !== m_cnt || overflow !== m_ovf) begin
        $display("FAIL random: iter %0d cnt_out=%h overflow=%b, want %h/%b", i, cnt_out, overflow, m_cnt, m_ovf);
        bad++;
      end
    end
  endtask

  task automatic test_async_reset();
    drive_step(1'b1, 1'b0, 32'h0000_0055);
    enable = 1'b1; load = 1'b0;
    #2;
    res_n = 1'b0;
    #1;
    total++;
    if (cnt_out !== 32'd0 || overflow !== 1'b0) begin
      $display("FAIL async_reset: cnt_out=%h overflow=%b, want 0/0", cnt_out, overflow);
      bad++;
    end
    res_n = 1'b1;
    m_cnt = 32'd0; m_ovf = 1'b0;
    drive_step(1'b1, 1'b0, 32'hFFFF_FFFF);
    drive_step(1'b0, 1'b1, 32'h0);
    #2;
    res_n = 1'b0;
    #1;
    total++;
    if (overflow !== 1'b0 || cnt_out !== 32'd0) begin
      $display("FAIL reset_clears_pulse: cnt_out=%h overflow=%b, want 0/0", cnt_out, overflow);
      bad++;
    end
    for (int i = 0; i < 2; i++) begin
      load = 1'b1; enable = 1'b1; cnt_in = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      total++;
      if (cnt_out !== 32'd0 || overflow !== 1'b0) begin
        $display("FAIL reset_ignores_inputs: cnt_out=%h overflow=%b, want 0/0", cnt_out, overflow);
        bad++;
      end
    end
    load = 1'b0; enable = 1'b0;
    res_n = 1'b1;
    m_cnt = 32'd0; m_ovf = 1'b0;
    drive_step(1'b0, 1'b1, 32'h0);
    total++;
    if (cnt_out !== 32'd1) begin
      $display("FAIL count_after_reset: cnt_out=%h, want 1", cnt_out);
      bad++;
    end
  endtask

  task automatic test_small_width();
    int pulses;
    int exp_v;
    pulses = 0;
    res4_n = 1'b0; en4 = 1'b1; load4 = 1'b0; cnt_in4 = 4'hF;
    @(posedge clk); #1;
    total++;
    if (cnt_out4 !== 4'd0 || ovf4 !== 1'b0) begin
      $display("FAIL w4_reset: cnt_out=%h overflow=%b, want 0/0", cnt_out4, ovf4);
      bad++;
    end
    res4_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      exp_v = i % 16;
      if (ovf4 === 1'b1) pulses++;
      total++;
      if (cnt_out4 !== 4'(exp_v) || ovf4 !== (i == 16)) begin
        $display("FAIL w4_count: edge %0d cnt_out=%0d overflow=%b, want %0d/%b", i, cnt_out4, ovf4, exp_v, (i == 16));
        bad++;
      end
    end
    total++;
    if (pulses !== 1) begin
      $display("FAIL w4_pulses: got %0d overflow pulses, want 1", pulses);
      bad++;
    end
  endtask

  initial begin
    res4_n = 1'b0; en4 = 1'b0; load4 = 1'b0; cnt_in4 = 4'h0;
    test_reset();
    test_pause();
    test_load_priority();
    test_wrap();
    test_random();
    test_async_reset();
    test_small_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
